// File: rtl/sample_framer.sv
`default_nettype none
// ============================================================================
// Module   : sample_framer
// Purpose  : Collects DATA_LEN samples over valid/ready, pulses start, then
//            replays the frame at one sample per clock for the boxcar filter.
// Revision : 1.0
// ============================================================================
module sample_framer #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_LEN   = 50
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  flush,
   output logic                  start,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  sample_valid,
   output logic                  frame_done,
   output logic [15:0]           frame_count
);

   localparam int               IDX_W      = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_LEN - 1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_ARM    = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t                state_q;
   logic [IDX_W-1:0]      wr_idx_q;
   logic [IDX_W-1:0]      rd_idx_q;
   logic                  start_q;
   logic                  sample_valid_q;
   logic                  frame_done_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic [15:0]           frame_count_q;
   logic [DATA_WIDTH-1:0] buf_q [DATA_LEN];
   logic                  w_accept;

   assign in_ready     = (state_q == S_FILL) && !flush;
   assign w_accept     = in_valid && in_ready;
   assign start        = start_q;
   assign data_out     = data_out_q;
   assign sample_valid = sample_valid_q;
   assign frame_done   = frame_done_q;
   assign frame_count  = frame_count_q;

   // Frame storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         buf_q[wr_idx_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_FILL;
         wr_idx_q       <= '0;
         rd_idx_q       <= '0;
         start_q        <= 1'b0;
         sample_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         data_out_q     <= '0;
         frame_count_q  <= '0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (flush) begin
                  wr_idx_q <= '0;
               end else if (in_valid) begin
                  if (wr_idx_q == C_LAST_IDX) begin
                     wr_idx_q <= '0;
                     start_q  <= 1'b1;
                     state_q  <= S_ARM;
                  end else begin
                     wr_idx_q <= wr_idx_q + 1'b1;
                  end
               end
            end
            S_ARM: begin
               start_q        <= 1'b0;
               data_out_q     <= buf_q[0];
               rd_idx_q       <= IDX_W'(1);
               sample_valid_q <= 1'b1;
               state_q        <= S_STREAM;
            end
            S_STREAM: begin
               // frame_done_q marks the cycle currently presenting the last sample.
               if (frame_done_q) begin
                  frame_done_q   <= 1'b0;
                  sample_valid_q <= 1'b0;
                  data_out_q     <= '0;
                  rd_idx_q       <= '0;
                  frame_count_q  <= frame_count_q + 16'd1;
                  state_q        <= S_FILL;
               end else begin
                  data_out_q   <= buf_q[rd_idx_q];
                  rd_idx_q     <= rd_idx_q + 1'b1;
                  frame_done_q <= (rd_idx_q == C_LAST_IDX);
               end
            end
            default: begin
               state_q <= S_FILL;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sample_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_framer
// Purpose  : Directed scoreboard bench for sample_framer (DATA_LEN = 50).
// Revision : 1.0
// ============================================================================
module tb_sample_framer;

   localparam int DW = 8;
   localparam int DL = 50;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic          flush    = 1'b0;
   logic          in_ready;
   logic          start;
   logic [DW-1:0] data_out;
   logic          sample_valid;
   logic          frame_done;
   logic [15:0]   frame_count;

   sample_framer #(.DATA_WIDTH(DW), .DATA_LEN(DL)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .flush        (flush),
      .start        (start),
      .data_out     (data_out),
      .sample_valid (sample_valid),
      .frame_done   (frame_done),
      .frame_count  (frame_count)
   );

   always #5 clk = ~clk;

   int            checks     = 0;
   int            errors     = 0;
   int            exp_frames = 0;
   logic [DW-1:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every replayed sample must match the next expected one.
   logic [DW-1:0] mon_e;
   always @(negedge clk) begin
      if (sample_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL replay_unexpected: got %0h expected no sample at %0t", data_out, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("replay_data", 32'(data_out), 32'(mon_e));
            check("ready_low_in_stream", 32'(in_ready), 32'd0);
         end
      end
   end

   task automatic send(input logic [DW-1:0] v, output int waited);
      in_valid = 1'b1;
      in_data  = v;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!frame_done && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!frame_done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no frame_done expected pulse at %0t", name, $time);
      end
      exp_frames++;
      @(negedge clk);
      check({name, "_frame_count"}, 32'(frame_count), 32'(exp_frames));
      check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Continuous source, cycle-exact timing of one frame.
      for (int i = 0; i < DL; i++) exp_q.push_back(8'(i));
      for (int c = 1; c <= 103; c++) begin
         in_valid = (c <= DL);
         in_data  = 8'(c - 1);
         @(negedge clk);
         if (c == 1) begin
            check("rst_data_out", 32'(data_out), 32'd0);
            check("rst_sample_valid", 32'(sample_valid), 32'd0);
            check("rst_frame_count", 32'(frame_count), 32'd0);
         end
         check("t_start", 32'(start), 32'(c == 51));
         check("t_sample_valid", 32'(sample_valid), 32'(c >= 52 && c <= 101));
         check("t_frame_done", 32'(frame_done), 32'(c == 101));
         check("t_in_ready", 32'(in_ready), 32'(c <= 50 || c >= 102));
         check("t_frame_count", 32'(frame_count), 32'(c >= 102));
         if (!sample_valid) check("t_data_idle", 32'(data_out), 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid   = 1'b0;
      exp_frames = 1;
      check("t_sb_empty", 32'(exp_q.size()), 32'd0);

      // Bursty source: valid every other cycle.
      for (int i = 0; i < DL; i++) exp_q.push_back(8'(i * 7 + 3));
      for (int i = 0; i < DL; i++) begin
         @(posedge clk);
         #1;
         send(8'(i * 7 + 3), w);
      end
      wait_frame("burst");

      // Flush partial frame with a colliding valid; flush during replay is ignored.
      for (int i = 0; i < 20; i++) send(8'(200 + i), w);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      @(negedge clk);
      check("flush_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < DL; i++) exp_q.push_back(8'(100 + i));
      for (int i = 0; i < DL; i++) send(8'(100 + i), w);
      flush = 1'b1;
      wait_frame("flush");
      flush = 1'b0;

      // Back-pressure: held sample lands as buffer[0] of the next frame.
      for (int i = 0; i < DL; i++) exp_q.push_back(8'(50 + i));
      exp_q.push_back(8'hAA);
      for (int i = 1; i < DL; i++) exp_q.push_back(8'(150 + i));
      for (int i = 0; i < DL; i++) send(8'(50 + i), w);
      send(8'hAA, w);
      check("bp_wait_cycles", 32'(w), 32'(DL + 1));
      exp_frames++;
      check("bp_first_count", 32'(frame_count), 32'(exp_frames));
      for (int i = 1; i < DL; i++) send(8'(150 + i), w);
      wait_frame("bp");

      // Reset on replay cycle k=10 abandons the frame.
      for (int i = 0; i < DL; i++) exp_q.push_back(8'(i * 3));
      for (int i = 0; i < DL; i++) send(8'(i * 3), w);
      n = 0;
      @(negedge clk);
      while (!start && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("rst_test_start", 32'(start), 32'd1);
      repeat (11) @(negedge clk);
      check("rst_test_k10_valid", 32'(sample_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_start", 32'(start), 32'd0);
      check("mid_rst_data_out", 32'(data_out), 32'd0);
      check("mid_rst_sample_valid", 32'(sample_valid), 32'd0);
      check("mid_rst_frame_done", 32'(frame_done), 32'd0);
      check("mid_rst_frame_count", 32'(frame_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      exp_frames = 0;
      @(posedge clk);
      #1;

      for (int i = 0; i < DL; i++) exp_q.push_back(8'(255 - i));
      for (int i = 0; i < DL; i++) send(8'(255 - i), w);
      wait_frame("fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sample_framer.md
# sample_framer

Upstream feeder for the boxcar averaging filter (SF). It accepts samples from the acquisition source over a valid/ready handshake and collects one frame of DATA_LEN samples in an internal buffer. It then issues the filter's one-cycle `start` pulse and replays the frame at exactly one sample per clock on the cycles the filter consumes them. After the replay it returns to collecting the next frame.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width; must match the filter's DATA_WIDTH.
- DATA_LEN, 50, samples per frame; must match the filter's DATA_LEN; must be ≥ 2.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source has a sample on in_data.
- in_data  in  DATA_WIDTH  source sample.
- in_ready  out  1  framer accepts in_data this cycle; combinational: high only in FILL with flush low.
- flush  in  1  discard the partial frame; honoured only in FILL.
- start  out  1  one-cycle pulse to filter `start`.
- data_out  out  DATA_WIDTH  to filter `data_in`; registered.
- sample_valid  out  1  data_out holds a frame sample this cycle.
- frame_done  out  1  one-cycle pulse on the last replay cycle.
- frame_count  out  16  completed frames; wraps 0xFFFF→0.

## Operation
- Buffer: DATA_LEN × DATA_WIDTH register array. wr_idx and rd_idx are $clog2(DATA_LEN) bits wide.
- FILL:
  - in_ready = !flush.
  - On in_valid && in_ready: buffer[wr_idx] ← in_data and wr_idx increments.
  - On the accept with wr_idx == DATA_LEN-1: wr_idx ← 0 and go to ARM.
  - flush high: wr_idx ← 0 and no sample is written. flush has priority over a simultaneous in_valid; in_ready is low, so no handshake occurs.
- ARM (exactly 1 cycle):
  - start = 1, in_ready = 0.
  - Registers load data_out ← buffer[0] and rd_idx ← 1.
  - Go to STREAM.
- STREAM (exactly DATA_LEN cycles):
  - sample_valid = 1, in_ready = 0.
  - Replay cycle k (k = 0..DATA_LEN-1) presents data_out = buffer[k].
  - The register loads buffer[rd_idx] for the next cycle, and rd_idx increments.
  - On cycle k = DATA_LEN-1:
    - frame_done = 1;
    - frame_count increments;
    - data_out ← 0 at the clock edge;
    - go to FILL.
- flush is ignored in ARM and STREAM; a started frame always replays completely.
- Outside STREAM, data_out = 0 and sample_valid = 0.
- The source must hold in_data stable while in_valid && !in_ready. No sample is ever dropped or duplicated.
- The framer never resets the filter. The filter re-arms on each `start`.

## Timing
- Reset values: state FILL, wr_idx = 0, rd_idx = 0, start = 0, data_out = 0, sample_valid = 0, frame_done = 0, frame_count = 0.
  - in_ready = 1 in the first cycle after reset if flush is low.
  - Buffer contents are not reset.
- Let T be the cycle of the final (DATA_LEN-th) accept:
  - T+1: start high (ARM).
  - T+2 … T+1+DATA_LEN: sample_valid high with buffer[0..DATA_LEN-1]. T+2 is the first cycle the filter samples data_in after `start`.
  - T+1+DATA_LEN: frame_done high.
  - T+2+DATA_LEN: FILL; in_ready high again.
- Minimum frame period, with the source always valid: 2·DATA_LEN + 1 cycles.
- rst mid-frame, in any state, on the next edge:
  - all outputs return to reset values;
  - the partial or in-flight frame is abandoned;
  - frame_count is cleared;
  - no start or frame_done pulse is emitted.
- frame_count wraps to 0 on the 65536th frame without any flag.

## Test plan
- DATA_LEN=50, source always valid with in_data = 0..49, accepts at cycles 1..50 → start at cycle 51 only. Cycles 52..101: data_out = 0..49 with sample_valid high. frame_done at 101 only; frame_count = 1; in_ready high at 102.
- Bursty source: in_valid toggles every other cycle, value held while not ready → the replayed sequence exactly equals the accepted sequence; 50 accepts occur before start.
- Flush: accept 20 samples, flush for 1 cycle with in_valid high, then 50 samples 100..149 → replay is 100..149; the flushed-cycle sample is absent. flush asserted during STREAM has no effect.
- Back-pressure: in_valid held high during ARM/STREAM → in_ready stays 0; the held sample is accepted in the first FILL cycle as buffer[0] of the next frame.
- rst asserted on replay cycle k=10 → next cycle all outputs are 0 and frame_count = 0. A fresh 50-sample frame then replays correctly.
- Integration with SF (FILT_SIZE=4, DATA_LEN=50), frame of all 10s → every filtered_data entry that SF writes equals 10; SF sees data_in only while sample_valid is high.
